// File: rtl/free_list_nway.sv
// free_list_nway: circular free list of physical register tags with age-ordered multi-way alloc/retire and one-cycle squash recovery.
// Define FL_CHECK_EN to enable the sticky fl_error protocol checker.
module free_list_nway #(
   parameter int PR_NUM = 64,
   parameter int AR_NUM = 32,
   parameter int DIS_W = 3,
   parameter int RET_W = 3,
   localparam int PRW = $clog2(PR_NUM),
   localparam int D = PR_NUM - AR_NUM,
   localparam int PW = (D > 1) ? $clog2(D) : 1,
   localparam int CW = $clog2(D + 1)
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [DIS_W-1:0]     dis_new_pr_en,
   output logic [DIS_W*PRW-1:0] free_pr,
   output logic [DIS_W-1:0]     free_pr_valid,
   input  logic [RET_W-1:0]     retire_en,
   input  logic [RET_W*PRW-1:0] retire_pr,
   input  logic                 squash,
   output logic [CW-1:0]        free_count,
   output logic                 fl_error
);
   logic [PRW-1:0] slots [D];
   logic [PW-1:0] head, tail, head_n, tail_n;
   logic [CW-1:0] count, count_n;
   logic [RET_W-1:0] wr_en;
   logic [PW-1:0] wr_idx [RET_W];
   int pops, pushes;

   function automatic logic [PW-1:0] wrap(input logic [PW-1:0] b, input int o);
      int s;
      s = int'(b) + o;
      return PW'(s >= D ? s - D : s);
   endfunction

   // oldest enabled way takes head; disabled ways preview the next candidate
   always_comb begin : alloc
      int n;
      logic v;
      n = 0;
      pops = 0;
      free_pr = '0;
      free_pr_valid = '0;
      for (int i = DIS_W - 1; i >= 0; i--) begin
         v = n < int'(count);
         free_pr[i*PRW +: PRW] = slots[wrap(head, n)];
         free_pr_valid[i] = v;
         if (dis_new_pr_en[i]) begin
            n++;
            if (v) pops++;
         end
      end
   end

   // pushes beyond the free space are dropped so count never exceeds D
   always_comb begin : push
      int m, room;
      logic v;
      room = D - int'(count) + pops;
      m = 0;
      wr_en = '0;
      for (int i = RET_W - 1; i >= 0; i--) begin
         v = retire_en[i] && (m < room);
         wr_idx[i] = wrap(tail, m);
         wr_en[i] = v;
         if (v) m++;
      end
      pushes = m;
   end

   assign tail_n = wrap(tail, pushes);
   assign head_n = squash ? tail_n : wrap(head, pops);
   assign count_n = squash ? CW'(D) : CW'(int'(count) - pops + pushes);
   assign free_count = count;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < D; k++) slots[k] <= PRW'(AR_NUM + k);
         head <= '0;
         tail <= '0;
         count <= CW'(D);
      end else begin
         for (int i = 0; i < RET_W; i++)
            if (wr_en[i]) slots[wr_idx[i]] <= retire_pr[i*PRW +: PRW];
         head <= head_n;
         tail <= tail_n;
         count <= count_n;
      end
   end

`ifdef FL_CHECK_EN
   logic err_now;

   always_comb begin : check
      err_now = (int'(count) - pops + $countones(retire_en)) > D;
      for (int i = 0; i < RET_W; i++) begin
         if (retire_en[i]) begin
            if (int'(retire_pr[i*PRW +: PRW]) >= PR_NUM) err_now = 1'b1;
            for (int j = 0; j < D; j++)
               if (j < int'(count) && slots[wrap(head, j)] == retire_pr[i*PRW +: PRW]) err_now = 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         fl_error <= 1'b0;
      end else if (err_now) begin
         fl_error <= 1'b1;
         $error("free_list_nway: protocol violation (overflow, duplicate or out-of-range tag)");
      end
   end
`else
   assign fl_error = 1'b0;
`endif
endmodule

// File: tb/tb_free_list_nway.sv
// tb_free_list_nway: table-driven directed check of free_list_nway allocation, retire, wrap, reset and squash.
module tb_free_list_nway;
   logic clock = 1'b0;
   logic reset = 1'b0;
   logic [2:0] dis = '0, ren = '0;
   logic [17:0] rpr = '0;
   logic sq = 1'b0;
   logic [17:0] free_pr;
   logic [2:0] vld;
   logic [5:0] cnt;
   logic err;
   int tests = 0, fails = 0;

   always #5 clock = ~clock;

   free_list_nway dut (
      .clock(clock),
      .reset(reset),
      .dis_new_pr_en(dis),
      .free_pr(free_pr),
      .free_pr_valid(vld),
      .retire_en(ren),
      .retire_pr(rpr),
      .squash(sq),
      .free_count(cnt),
      .fl_error(err)
   );

   typedef struct {
      logic rstn;
      logic [2:0] d_en;
      logic [2:0] r_en;
      logic [17:0] r_pr;
      logic sqsh;
      logic [17:0] e_pr;
      logic [2:0] e_v;
      logic [5:0] e_cnt;
   } vec_t;

   vec_t tbl[$];

   function automatic logic [17:0] p3(input int a, input int b, input int c);
      return {a[5:0], b[5:0], c[5:0]};
   endfunction

   function automatic void add(input logic rn, input logic [2:0] de, input logic [2:0] re,
                               input logic [17:0] rp, input logic s, input logic [17:0] ep,
                               input logic [2:0] ev, input int ec);
      vec_t r;
      r.rstn = rn; r.d_en = de; r.r_en = re; r.r_pr = rp; r.sqsh = s;
      r.e_pr = ep; r.e_v = ev; r.e_cnt = 6'(ec);
      tbl.push_back(r);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   initial begin
      add(0, 3'b111, 0, 0, 0, p3(32, 33, 34), 3'b111, 32);
      add(1, 3'b000, 0, 0, 0, p3(32, 32, 32), 3'b111, 32);
      add(1, 3'b101, 0, 0, 0, p3(32, 33, 33), 3'b111, 32);
      for (int k = 0; k < 9; k++) add(1, 3'b111, 0, 0, 0, p3(34 + 3*k, 35 + 3*k, 36 + 3*k), 3'b111, 30 - 3*k);
      add(1, 3'b001, 0, 0, 0, p3(61, 61, 61), 3'b111, 3);
      add(1, 3'b111, 0, 0, 0, p3(62, 63, 32), 3'b110, 2);
      add(1, 3'b000, 0, 0, 0, p3(32, 32, 32), 3'b000, 0);
      add(1, 3'b000, 3'b111, p3(5, 6, 7), 0, p3(32, 32, 32), 3'b000, 0);
      add(1, 3'b111, 0, 0, 0, p3(5, 6, 7), 3'b111, 3);
      add(0, 3'b111, 0, 0, 0, p3(32, 33, 34), 3'b111, 32);
      for (int k = 0; k < 4; k++) add(1, 3'b111, 0, 0, 0, p3(32 + 3*k, 33 + 3*k, 34 + 3*k), 3'b111, 32 - 3*k);
      add(1, 3'b110, 3'b100, p3(9, 0, 0), 0, p3(44, 45, 46), 3'b111, 20);
      add(1, 3'b000, 0, 0, 0, p3(46, 46, 46), 3'b111, 19);
      add(0, 3'b000, 0, 0, 0, p3(32, 32, 32), 3'b111, 32);
      add(1, 3'b111, 0, 0, 0, p3(32, 33, 34), 3'b111, 32);
      add(1, 3'b111, 0, 0, 0, p3(35, 36, 37), 3'b111, 29);
      add(1, 3'b000, 3'b100, p3(10, 0, 0), 1, p3(38, 38, 38), 3'b111, 26);
      add(1, 3'b111, 0, 0, 0, p3(33, 34, 35), 3'b111, 32);
      for (int k = 0; k < 9; k++) add(1, 3'b111, 0, 0, 0, p3(36 + 3*k, 37 + 3*k, 38 + 3*k), 3'b111, 29 - 3*k);
      add(1, 3'b111, 0, 0, 0, p3(63, 10, 33), 3'b110, 2);

      foreach (tbl[i]) begin
         @(negedge clock);
         reset = tbl[i].rstn; dis = tbl[i].d_en; ren = tbl[i].r_en; rpr = tbl[i].r_pr; sq = tbl[i].sqsh;
         #2;
         chk($sformatf("row%0d_pr", i), 32'(free_pr), 32'(tbl[i].e_pr));
         chk($sformatf("row%0d_valid", i), 32'(vld), 32'(tbl[i].e_v));
         chk($sformatf("row%0d_count", i), 32'(cnt), 32'(tbl[i].e_cnt));
      end

      // full list: a retire with no pops must be dropped
      @(negedge clock);
      reset = 1'b0; dis = '0; ren = '0; sq = 1'b0;
      @(negedge clock);
      reset = 1'b1; ren = 3'b100; rpr = p3(5, 0, 0);
      #2 chk("ovf_cnt_before", 32'(cnt), 32);
      @(negedge clock);
      ren = '0;
      #2;
      chk("ovf_cnt_after", 32'(cnt), 32);
      chk("ovf_pr_after", 32'(free_pr), 32'(p3(32, 32, 32)));
      chk("ovf_err", 32'(err), 0);
      // full list: one pop and one retire together keep it full
      @(negedge clock);
      dis = 3'b100; ren = 3'b100; rpr = p3(7, 0, 0);
      #2 chk("full_swap_pr", 32'(free_pr), 32'(p3(32, 33, 33)));
      @(negedge clock);
      dis = '0; ren = '0;
      #2;
      chk("full_swap_cnt", 32'(cnt), 32);
      chk("full_swap_head", 32'(free_pr), 32'(p3(33, 33, 33)));
      chk("full_swap_err", 32'(err), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
